// File: rtl/lc4_pipe_pkg.sv
// ---------------------------------------------------------------------------
// lc4_pipe_pkg
// Shared constants and types for the LC4 pipeline stages.
//   REG_SEL_W  width of a register selector (8 architectural registers)
//   NUM_REGS   number of architectural registers
//   SB_W       default width of one scoreboard counter
//   DATA_W     default data / PC word width
//   INSN_W     instruction word width
//   stage_payload_t  everything the operand-fetch stage hands to execute
// ---------------------------------------------------------------------------
package lc4_pipe_pkg;

    localparam int REG_SEL_W = 3;
    localparam int NUM_REGS  = 8;
    localparam int SB_W      = 2;
    localparam int DATA_W    = 16;
    localparam int INSN_W    = 16;

    // Execute-side entry. The data fields use DATA_W, so a stage built on
    // this payload must be instantiated with its word width equal to DATA_W.
    typedef struct packed {
        logic [INSN_W-1:0]    insn;
        logic [DATA_W-1:0]    pc;
        logic [DATA_W-1:0]    rs_data;
        logic [DATA_W-1:0]    rt_data;
        logic [REG_SEL_W-1:0] rd;
        logic                 rd_we;
    } stage_payload_t;

endpackage

// File: rtl/lc4_scoreboard.sv
// ---------------------------------------------------------------------------
// lc4_scoreboard
// One small counter per architectural register, counting writes that have
// issued but not yet written back.
//   clk, rst          clock, asynchronous active-low reset
//   gwe               global write enable; counters freeze while 0
//   i_clear           flush: all counters to zero, writeback ignored
//   i_inc_en/_reg     an instruction writing i_inc_reg issues this cycle
//   i_dec_en/_reg     a writeback to i_dec_reg happens this cycle
//   i_rs, i_rt        source selectors to check
//   i_rd              destination selector to check
//   o_rs_busy         rs still has a write in flight after this cycle's writeback
//   o_rt_busy         same for rt
//   o_rd_full         rd counter is saturated and no writeback frees a slot
// ---------------------------------------------------------------------------
module lc4_scoreboard
    import lc4_pipe_pkg::*;
#(
    parameter int SB_W = lc4_pipe_pkg::SB_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gwe,
    input  logic                 i_clear,
    input  logic                 i_inc_en,
    input  logic [REG_SEL_W-1:0] i_inc_reg,
    input  logic                 i_dec_en,
    input  logic [REG_SEL_W-1:0] i_dec_reg,
    input  logic [REG_SEL_W-1:0] i_rs,
    input  logic [REG_SEL_W-1:0] i_rt,
    input  logic [REG_SEL_W-1:0] i_rd,
    output logic                 o_rs_busy,
    output logic                 o_rt_busy,
    output logic                 o_rd_full
);

    localparam logic [SB_W-1:0] CNT_MAX = '1;
    localparam logic [SB_W-1:0] CNT_ONE = SB_W'(1);

    logic [SB_W-1:0]     r_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;

    // One-hot increment / decrement vectors.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (i_inc_en) w_inc[i_inc_reg] = 1'b1;
        if (i_dec_en) w_dec[i_dec_reg] = 1'b1;
    end

    // Busy is judged net of this cycle's writeback, so a dependent
    // instruction can issue in the same cycle as the producer's writeback
    // (the top bypasses the data). A full destination is likewise released
    // by a same-cycle writeback.
    always_comb begin
        o_rs_busy = (r_cnt[i_rs] - SB_W'(w_dec[i_rs])) != '0;
        o_rt_busy = (r_cnt[i_rt] - SB_W'(w_dec[i_rt])) != '0;
        o_rd_full = (r_cnt[i_rd] == CNT_MAX) && !w_dec[i_rd];
    end

    // Counter update. Inc and dec on the same register cancel; a stray
    // decrement of an empty counter is dropped rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
        end else if (gwe) begin
            if (i_clear) begin
                for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
            end else begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (w_inc[r] && !w_dec[r]) begin
                        r_cnt[r] <= r_cnt[r] + CNT_ONE;
                    end else if (!w_inc[r] && w_dec[r] && (r_cnt[r] != '0)) begin
                        r_cnt[r] <= r_cnt[r] - CNT_ONE;
                    end
                end
            end
        end
    end

    // A writeback to a register with nothing in flight means the pipeline
    // and the scoreboard have lost track of each other.
    a_no_dec_at_zero : assert property (
        @(posedge clk) disable iff (!rst)
        (gwe && !i_clear && i_dec_en && !(i_inc_en && (i_inc_reg == i_dec_reg)))
            |-> (r_cnt[i_dec_reg] != '0)
    );

endmodule

// File: rtl/lc4_operand_fetch.sv
// ---------------------------------------------------------------------------
// lc4_operand_fetch
// Decode->execute stage: reads rs/rt from the register file, bypasses a
// same-cycle writeback, stalls on RAW hazards via the scoreboard and hands
// the operands to execute over a valid/ready handshake.
//   clk, rst                 clock, asynchronous active-low reset
//   gwe                      global write enable
//   i_valid / o_ready        decode-side handshake
//   i_insn, i_pc             passed through to execute
//   i_rs, i_rt, i_rs_re, i_rt_re   source selectors and read enables
//   i_rd, i_rd_we            destination and its write enable
//   o_rf_rs, o_rf_rt         regfile read selectors (combinational)
//   i_rf_rs_data/_rt_data    regfile read data
//   i_wb_rd, i_wb_we, i_wb_data    regfile write port, observed
//   i_flush                  squash this stage and all in-flight writes
//   o_valid / i_ready        execute-side handshake
//   o_insn .. o_rd_we        registered execute-side entry
// ---------------------------------------------------------------------------
module lc4_operand_fetch
    import lc4_pipe_pkg::*;
#(
    parameter int n    = DATA_W,
    parameter int SB_W = lc4_pipe_pkg::SB_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gwe,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [INSN_W-1:0]    i_insn,
    input  logic [n-1:0]         i_pc,
    input  logic [REG_SEL_W-1:0] i_rs,
    input  logic [REG_SEL_W-1:0] i_rt,
    input  logic                 i_rs_re,
    input  logic                 i_rt_re,
    input  logic [REG_SEL_W-1:0] i_rd,
    input  logic                 i_rd_we,
    output logic [REG_SEL_W-1:0] o_rf_rs,
    output logic [REG_SEL_W-1:0] o_rf_rt,
    input  logic [n-1:0]         i_rf_rs_data,
    input  logic [n-1:0]         i_rf_rt_data,
    input  logic [REG_SEL_W-1:0] i_wb_rd,
    input  logic                 i_wb_we,
    input  logic [n-1:0]         i_wb_data,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [INSN_W-1:0]    o_insn,
    output logic [n-1:0]         o_pc,
    output logic [n-1:0]         o_rs_data,
    output logic [n-1:0]         o_rt_data,
    output logic [REG_SEL_W-1:0] o_rd,
    output logic                 o_rd_we
);

    logic           r_valid;
    stage_payload_t r_payload;
    stage_payload_t w_next_payload;

    logic   [n-1:0] w_rs_data;
    logic   [n-1:0] w_rt_data;
    logic           w_rs_busy;
    logic           w_rt_busy;
    logic           w_rd_full;
    logic           w_hazard;
    logic           w_issue;

    assign o_rf_rs = i_rs;
    assign o_rf_rt = i_rt;

    // The regfile only shows a write after the edge, so a writeback landing
    // this cycle must be forwarded in place of the stale read data.
    always_comb begin
        w_rs_data = (i_wb_we && (i_wb_rd == i_rs)) ? i_wb_data : i_rf_rs_data;
        w_rt_data = (i_wb_we && (i_wb_rd == i_rt)) ? i_wb_data : i_rf_rt_data;
    end

    lc4_scoreboard #(
        .SB_W (SB_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .gwe       (gwe),
        .i_clear   (i_flush),
        .i_inc_en  (w_issue && i_rd_we),
        .i_inc_reg (i_rd),
        .i_dec_en  (i_wb_we),
        .i_dec_reg (i_wb_rd),
        .i_rs      (i_rs),
        .i_rt      (i_rt),
        .i_rd      (i_rd),
        .o_rs_busy (w_rs_busy),
        .o_rt_busy (w_rt_busy),
        .o_rd_full (w_rd_full)
    );

    // Unused sources never stall; a saturated destination counter does.
    always_comb begin
        w_hazard = (i_rs_re && w_rs_busy) || (i_rt_re && w_rt_busy) || (i_rd_we && w_rd_full);
        o_ready  = gwe && !i_flush && !w_hazard && (!r_valid || i_ready);
        w_issue  = i_valid && o_ready;
    end

    always_comb begin
        w_next_payload.insn    = i_insn;
        w_next_payload.pc      = i_pc;
        w_next_payload.rs_data = w_rs_data;
        w_next_payload.rt_data = w_rt_data;
        w_next_payload.rd      = i_rd;
        w_next_payload.rd_we   = i_rd_we;
    end

    // Execute-side entry. Flush beats issue; the payload only changes on
    // issue, so a stalled entry holds bit-stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (gwe) begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (w_issue) begin
                r_valid   <= 1'b1;
                r_payload <= w_next_payload;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_insn    = r_payload.insn;
    assign o_pc      = r_payload.pc;
    assign o_rs_data = r_payload.rs_data;
    assign o_rt_data = r_payload.rt_data;
    assign o_rd      = r_payload.rd;
    assign o_rd_we   = r_payload.rd_we;

endmodule
